multiply_seq_unit: RTL and testbench

Parametrised, iterative XLEN×XLEN multiplier for the EX stage of the RISC-V pipeline, implementing all four RV32M/RV64M multiply variants (MUL, MULH, MULHSU, MULHU). It replaces the fully combinational partial-product adder tree with a small shift-add datapath that retires BITS_PER_CYCLE multiplier bits per clock. The hazard unit stalls the pipeline on a valid/ready handshake while the operation is in flight, and can flush it.

---
 rtl/multiply_seq_unit_if.sv | 42 ++++
 rtl/multiply_seq_unit.sv | 149 ++++++++++++++
 tb/tb_multiply_seq_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiply_seq_unit_if.sv
// -----------------------------------------------------------------------------
// multiply_seq_unit_if
// Bundles the issue and result handshakes of the iterative multiplier.
//
// Handshake rules (both channels):
//   - A transfer happens on a rising CLK edge where valid && ready are high.
//   - Once valid is raised, the payload stays stable until that transfer.
//   - ready never depends combinationally on valid (in_ready is decoded
//     from registered state only).
//   - flush aborts whatever is in flight and wins over both handshakes.
//
// Signals:
//   in_valid/in_ready, in_a, in_b, op : operation issue channel
//   flush                             : abort current operation
//   out_valid/out_ready, res          : result channel
//   busy                              : unit is not idle
// Modports: master = pipeline/hazard side, slave = multiplier.
// -----------------------------------------------------------------------------
interface multiply_seq_unit_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [1:0]      op;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            busy;

  modport master (
    output in_valid, in_a, in_b, op, flush, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, op, flush, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/multiply_seq_unit.sv
// -----------------------------------------------------------------------------
// multiply_seq_unit
// Iterative XLEN x XLEN multiplier for MUL / MULH / MULHSU / MULHU.
// Operands are converted to sign + magnitude on accept, the unsigned
// magnitudes are multiplied by shift-add retiring BITS_PER_CYCLE multiplier
// bits per CALC cycle, and the 2*XLEN product is negated in FIX when the
// signs differ.
//
// Parameters:
//   XLEN           : operand/result width (32 or 64)
//   BITS_PER_CYCLE : multiplier bits per CALC cycle (1, 2, 4, 8; divides XLEN)
// Ports:
//   CLK          : rising-edge clock
//   RST          : synchronous active-high reset
//   bus          : multiply_seq_unit_if.slave (issue/result handshakes, flush)
//   dbg_state_o  : current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
// Optional feature:
//   MUL_EARLY_OUT_EN : when defined, CALC ends as soon as the remaining
//                      multiplier bits are all zero.
// Latency (accept at edge T): out_valid rises at edge T+N+2, N=XLEN/BITS_PER_CYCLE.
// -----------------------------------------------------------------------------
module multiply_seq_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                CLK,
  input  logic                RST,
  multiply_seq_unit_if.slave  bus,
  output logic [1:0]          dbg_state_o
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * XLEN;
  localparam int SW = $clog2(PW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   prod_q;
  logic [XLEN-1:0] a_mag_q;
  logic [XLEN-1:0] mult_q;
  logic [XLEN-1:0] res_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic            neg_q;
  logic            out_valid_q;

  // Sign/magnitude decode of the incoming operands. Negating 0x80..0 yields
  // 0x80..0 again, which is the correct unsigned magnitude.
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] a_mag_d;
  logic [XLEN-1:0] b_mag_d;

  assign sign_a  = bus.in_a[XLEN-1] & ((bus.op == 2'b01) | (bus.op == 2'b10));
  assign sign_b  = bus.in_b[XLEN-1] & (bus.op == 2'b01);
  assign a_mag_d = sign_a ? -bus.in_a : bus.in_a;
  assign b_mag_d = sign_b ? -bus.in_b : bus.in_b;

  // One shift-add step: |a| times the low multiplier digit, placed at the
  // bit offset of the digits already consumed.
  logic [BITS_PER_CYCLE-1:0]      digit;
  logic [XLEN+BITS_PER_CYCLE-1:0] partial;
  logic [PW-1:0]                  addend;
  logic [PW-1:0]                  prod_fix;
  logic [SW-1:0]                  shamt;
  logic                           calc_done;

  assign digit    = mult_q[BITS_PER_CYCLE-1:0];
  assign partial  = {{BITS_PER_CYCLE{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, digit};
  assign shamt    = SW'(cnt_q) * SW'(BITS_PER_CYCLE);
  assign addend   = {{(PW-XLEN-BITS_PER_CYCLE){1'b0}}, partial} << shamt;
  assign prod_fix = neg_q ? -prod_q : prod_q;

  // CALC spends one cycle on the exit decision after its last step, which
  // keeps the early-out and fixed-latency builds on the same timing model.
`ifdef MUL_EARLY_OUT_EN
  assign calc_done = (cnt_q == CW'(N)) || (mult_q == '0);
`else
  assign calc_done = (cnt_q == CW'(N));
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      a_mag_q     <= '0;
      mult_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // Abort: nothing in flight survives, no result is produced.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is an accept.
          if (bus.in_valid) begin
            state_q <= S_CALC;
            prod_q  <= '0;
            a_mag_q <= a_mag_d;
            mult_q  <= b_mag_d;
            cnt_q   <= '0;
            op_q    <= bus.op;
            neg_q   <= sign_a ^ sign_b;
          end
        end
        S_CALC: begin
          if (calc_done) begin
            state_q <= S_FIX;
          end else begin
            prod_q <= prod_q + addend;
            mult_q <= mult_q >> BITS_PER_CYCLE;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        S_FIX: begin
          prod_q      <= prod_fix;
          res_q       <= (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_multiply_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_multiply_seq_unit
// Directed table, hand-written abort/backpressure sequences and randomized
// operations for multiply_seq_unit. Expected results come from a 2*XLEN
// arithmetic reference model; expected latency from the operand magnitude.
// -----------------------------------------------------------------------------
module tb_multiply_seq_unit #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
);
  localparam int N  = XLEN / BPC;
  localparam int PW = 2 * XLEN;
`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       CLK;
  logic       RST;
  logic [1:0] dbg_state;
  int         cyc;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  multiply_seq_unit_if #(.XLEN(XLEN)) bus ();

  multiply_seq_unit #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BPC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [PW-1:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = (op == 2'b01) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] mb;
    int h;
    mb = (op == 2'b01 && b[XLEN-1]) ? -b : b;
    h  = -1;
    for (int i = 0; i < XLEN; i++) if (mb[i]) h = i;
    if (EARLY) return (h < 0) ? 2 : (h / BPC + 3);
    return N + 2;
  endfunction

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic wait_ready(input string name);
    int waited = 0;
    while (!bus.in_ready && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    check(name, bus.in_ready, 1);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    wait_ready("start_ready");
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input int hold,
                       output logic [XLEN-1:0] got);
    int t_acc, lat, waited;
    logic [XLEN-1:0] held;
    got = '0;
    wait_ready("issue_ready");
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.in_a     = a;
    bus.in_b     = b;
    exp_q.push_back(ref_mul(op, a, b));
    @(negedge CLK);
    t_acc        = cyc;
    bus.in_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    waited = 0;
    while (!bus.out_valid && waited < N + 10) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    lat = cyc - t_acc;
    check("latency", lat, exp_lat(op, b));
    got = bus.res;
    check("res_vs_model", got, exp_q.pop_front());
    held = bus.res;
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;   // must not be taken while DONE
      @(negedge CLK);
      check("hold_res_stable", bus.res, held);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready_low", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    check("in_ready_after_handshake", bus.in_ready, 1);
    check("out_valid_dropped", bus.out_valid, 0);
    check("handshake_cycle", cyc - t_acc, lat + 1 + hold);
  endtask

  function automatic logic [XLEN-1:0] rand_opnd();
    logic [63:0] r;
    logic [XLEN-1:0] v;
    r = {$urandom(), $urandom()};
    v = r[XLEN-1:0];
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: begin v = '0; v[XLEN-1] = 1'b1; return v; end
      3: return XLEN'($urandom_range(0, 15));
      4: return v >> $urandom_range(0, XLEN - 1);
      default: return v;
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              hold;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [XLEN-1:0] ones, msb, got;
    int seen;

    ones = '1;
    msb  = '0;
    msb[XLEN-1] = 1'b1;

    vecs[0] = '{2'b00, XLEN'(7), XLEN'(6), XLEN'(42), 0};
    vecs[1] = '{2'b01, ones, ones, XLEN'(0), 0};
    vecs[2] = '{2'b00, ones, ones, XLEN'(1), 0};
    vecs[3] = '{2'b11, ones, ones, ones - XLEN'(1), 0};
    vecs[4] = '{2'b10, ones, ones, ones, 0};
    vecs[5] = '{2'b01, msb, msb, msb >> 1, 0};
    vecs[6] = '{2'b00, XLEN'(9), XLEN'(6), XLEN'(54), 5};
    vecs[7] = '{2'b00, XLEN'(9), XLEN'(1), XLEN'(9), 0};
    vecs[8] = '{2'b00, XLEN'(9), XLEN'(0), XLEN'(0), 0};
    vecs[9] = '{2'b01, XLEN'(3), ones, ones - XLEN'(2) + XLEN'(0) - ones + ones, 0};
    // vecs[9]: MULH 3 * -1 = -3, high half all ones
    vecs[9].exp = ones;

    cyc           = 0;
    RST           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.op        = 2'b00;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_res", bus.res, 0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, got);
      check($sformatf("tbl_res_%0d", i), got, vecs[i].exp);
    end

    // flush with in_valid in IDLE accepts nothing
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = 2'b00;
    bus.in_a     = XLEN'(5);
    bus.in_b     = XLEN'(5);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_idle_no_accept", bus.busy, 0);

    // flush in CALC cycle 10
    start_op(2'b11, ones, ones);
    repeat (9) @(negedge CLK);
    bus.flush = 1'b1;
    @(negedge CLK);
    bus.flush = 1'b0;
    check("flush_calc_busy", bus.busy, 0);
    check("flush_calc_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (N + 10) begin
      @(negedge CLK);
      if (bus.out_valid) seen++;
    end
    check("flush_calc_no_result", seen, 0);
    do_op(2'b00, XLEN'(3), XLEN'(5), 0, got);
    check("after_flush_mul", got, XLEN'(15));

    // flush while DONE drops the result
    start_op(2'b11, XLEN'(2), XLEN'(3));
    seen = 0;
    while (!bus.out_valid && seen < N + 10) begin
      @(negedge CLK);
      seen++;
    end
    check("done_reached", bus.out_valid, 1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_done_out_valid", bus.out_valid, 0);
    check("flush_done_in_ready", bus.in_ready, 1);

    // RST mid-CALC restores reset values
    start_op(2'b11, ones, ones);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_calc_busy", bus.busy, 0);
    check("rst_calc_in_ready", bus.in_ready, 1);
    check("rst_calc_out_valid", bus.out_valid, 0);
    check("rst_calc_res", bus.res, 0);
    seen = 0;
    repeat (N + 10) begin
      @(negedge CLK);
      if (bus.out_valid) seen++;
    end
    check("rst_calc_no_result", seen, 0);
    do_op(2'b00, XLEN'(3), XLEN'(5), 0, got);
    check("after_rst_mul", got, XLEN'(15));

    // randomized operations against the model (checked inside do_op)
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), $urandom_range(0, 3), got);
    end

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
